// File: rtl/spike_counter_mc.sv
// Multi-channel spike-rate counter: counts rising spike edges per channel and
// latches every channel's count together at each window boundary.
module spike_counter_mc #(
   parameter int unsigned N_CH          = 4,
   parameter int unsigned CNT_W         = 32,
   parameter int unsigned MODE_INTERNAL = 0,
   parameter int unsigned WIN_CYCLES    = 1000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_CH-1:0]        spike,
   input  logic                   slow_clk,
   input  logic                   enable,
   output logic [N_CH*CNT_W-1:0]  cnt_out,
   output logic                   cnt_valid,
   output logic [N_CH-1:0]        overflow,
   output logic [N_CH-1:0]        silent,
   output logic [15:0]            window_idx
);

   localparam int unsigned IDX_W    = 16;
   localparam int unsigned PER_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
   localparam bit          INT_MODE = (MODE_INTERNAL != 0);

   logic [N_CH-1:0]  r_spike_d;
   logic             r_slow_d;
   logic [PER_W-1:0] r_period;
   logic             r_valid;
   logic [IDX_W-1:0] r_win_idx;

   logic [N_CH-1:0]  w_edge;
   logic             w_per_last;
   logic             w_ext_bnd;
   logic             w_bnd;

   assign w_edge     = spike & ~r_spike_d & {N_CH{enable}};
   assign w_per_last = (r_period == PER_W'(WIN_CYCLES - 1));
   assign w_ext_bnd  = slow_clk & ~r_slow_d;
   assign w_bnd      = INT_MODE ? w_per_last : w_ext_bnd;

   // Input history is captured during reset too, so lines already high at release give no edge.
   always_ff @(posedge clk) begin
      r_spike_d <= spike;
      r_slow_d  <= slow_clk;
   end

   // Period counter only advances in internal mode; it wraps on the boundary cycle.
   always_ff @(posedge clk) begin
      if (reset || !INT_MODE || w_per_last) begin
         r_period <= '0;
      end else begin
         r_period <= r_period + PER_W'(1);
      end
   end

   // Window index is written every cycle so it always tracks its own value plus the boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid   <= 1'b0;
         r_win_idx <= '0;
      end else begin
         r_valid   <= w_bnd;
         r_win_idx <= r_win_idx + IDX_W'(w_bnd);
      end
   end

   assign cnt_valid  = r_valid;
   assign window_idx = r_win_idx;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [CNT_W-1:0] r_acc;
      logic             r_ovf_acc;
      logic [CNT_W-1:0] r_cnt;
      logic             r_ovf;
      logic             r_sil;
      logic             w_full;

      assign w_full = &r_acc;

      // Saturating accumulator; an edge on the boundary cycle opens the new window.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_sil     <= 1'b0;
         end else if (w_bnd) begin
            r_cnt     <= r_acc;
            r_ovf     <= r_ovf_acc;
            r_sil     <= (r_acc == '0);
            r_acc     <= CNT_W'(w_edge[i]);
            r_ovf_acc <= 1'b0;
         end else if (w_edge[i]) begin
            if (w_full) begin
               r_ovf_acc <= 1'b1;
            end else begin
               r_acc <= r_acc + CNT_W'(1);
            end
         end
      end

      assign cnt_out[i*CNT_W +: CNT_W] = r_cnt;
      assign overflow[i]               = r_ovf;
      assign silent[i]                 = r_sil;
   end

endmodule

// File: tb/tb_spike_counter_mc.sv
// Bench for spike_counter_mc: three instances (32-bit external, 4-bit external,
// 8-bit internal/10-cycle) against an integer window-count reference model.
module tb_spike_counter_mc;

   localparam int unsigned NCH   = 4;
   localparam int unsigned W_A   = 32;
   localparam int unsigned W_B   = 4;
   localparam int unsigned W_C   = 8;
   localparam int unsigned WIN_C = 10;
   localparam int unsigned ND    = 3;

   logic clk;
   logic reset;
   logic [NCH-1:0] spike;
   logic slow_clk;
   logic enable;

   logic [NCH*W_A-1:0] cnt_a;
   logic [NCH*W_B-1:0] cnt_b;
   logic [NCH*W_C-1:0] cnt_c;
   logic               v_o   [ND];
   logic [NCH-1:0]     ovf_o [ND];
   logic [NCH-1:0]     sil_o [ND];
   logic [15:0]        idx_o [ND];

   int n_run;
   int n_fail;
   int cyc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   spike_counter_mc #(.N_CH(NCH), .CNT_W(W_A), .MODE_INTERNAL(0), .WIN_CYCLES(WIN_C)) dut_a (
      .clk(clk), .reset(reset), .spike(spike), .slow_clk(slow_clk), .enable(enable),
      .cnt_out(cnt_a), .cnt_valid(v_o[0]), .overflow(ovf_o[0]), .silent(sil_o[0]),
      .window_idx(idx_o[0]));

   spike_counter_mc #(.N_CH(NCH), .CNT_W(W_B), .MODE_INTERNAL(0), .WIN_CYCLES(WIN_C)) dut_b (
      .clk(clk), .reset(reset), .spike(spike), .slow_clk(slow_clk), .enable(enable),
      .cnt_out(cnt_b), .cnt_valid(v_o[1]), .overflow(ovf_o[1]), .silent(sil_o[1]),
      .window_idx(idx_o[1]));

   spike_counter_mc #(.N_CH(NCH), .CNT_W(W_C), .MODE_INTERNAL(1), .WIN_CYCLES(WIN_C)) dut_c (
      .clk(clk), .reset(reset), .spike(spike), .slow_clk(slow_clk), .enable(enable),
      .cnt_out(cnt_c), .cnt_valid(v_o[2]), .overflow(ovf_o[2]), .silent(sil_o[2]),
      .window_idx(idx_o[2]));

   // Reference model: unbounded edge counts per window, clipped only when reported.
   int unsigned    m_edges [ND][NCH];
   logic [NCH-1:0] m_prev;
   logic           m_prev_slow;
   int unsigned    m_period;
   logic [31:0]    e_cnt   [ND][NCH];
   logic [NCH-1:0] e_ovf   [ND];
   logic [NCH-1:0] e_sil   [ND];
   logic [15:0]    e_idx   [ND];
   logic           e_valid [ND];
   logic           force_req;

   function automatic longint unsigned lim_of(int d);
      int unsigned w;
      w = (d == 0) ? W_A : ((d == 1) ? W_B : W_C);
      return (64'd1 << w) - 64'd1;
   endfunction

   function automatic logic [31:0] dut_cnt(int d, int ch);
      case (d)
         0:       return cnt_a[ch*W_A +: W_A];
         1:       return 32'(cnt_b[ch*W_B +: W_B]);
         default: return 32'(cnt_c[ch*W_C +: W_C]);
      endcase
   endfunction

   always @(posedge clk) begin : p_model
      logic [NCH-1:0] ed;
      logic bnd;
      longint unsigned lim;
      if (reset) begin
         for (int d = 0; d < ND; d++) begin
            for (int ch = 0; ch < NCH; ch++) begin
               m_edges[d][ch] = 0;
               e_cnt[d][ch]   = '0;
            end
            e_ovf[d] = '0; e_sil[d] = '0; e_idx[d] = '0; e_valid[d] = 1'b0;
         end
         m_period = 0;
      end else begin
         ed = spike & ~m_prev & {NCH{enable}};
         for (int d = 0; d < ND; d++) begin
            bnd = (d == 2) ? (m_period == WIN_C - 1) : (slow_clk && !m_prev_slow);
            lim = lim_of(d);
            e_valid[d] = bnd;
            if (bnd) begin
               e_idx[d] = e_idx[d] + 16'd1;
               for (int ch = 0; ch < NCH; ch++) begin
                  e_cnt[d][ch]  = (longint'(m_edges[d][ch]) > lim) ? 32'(lim) : 32'(m_edges[d][ch]);
                  e_ovf[d][ch]  = (longint'(m_edges[d][ch]) > lim);
                  e_sil[d][ch]  = (m_edges[d][ch] == 0);
                  m_edges[d][ch] = ed[ch] ? 1 : 0;
               end
            end else begin
               for (int ch = 0; ch < NCH; ch++) m_edges[d][ch] += ed[ch] ? 1 : 0;
            end
         end
         m_period = (m_period + 1) % WIN_C;
         if (force_req) e_idx[0] = 16'hFFFE;
      end
      m_prev      = spike;
      m_prev_slow = slow_clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset = 1'b1; spike = '0; slow_clk = 1'b0; enable = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic pulses(input logic [NCH-1:0] mask, input int n);
      for (int k = 0; k < n; k++) begin
         spike = mask; tick();
         spike = '0;   tick();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; slow_clk = 1'b0;
      for (int k = 0; k < 6; k++) begin
         spike = 4'($urandom); slow_clk = ~slow_clk; tick();
      end
      for (int d = 0; d < ND; d++) begin
         n_run++;
         if ({v_o[d], ovf_o[d], sil_o[d], idx_o[d]} !== '0) begin
            n_fail++;
            $display("FAIL reset_flags dut%0d: got v=%b ovf=%b sil=%b idx=%0d want all zero",
                     d, v_o[d], ovf_o[d], sil_o[d], idx_o[d]);
         end
         for (int ch = 0; ch < NCH; ch++) begin
            n_run++;
            if (dut_cnt(d, ch) !== 32'd0) begin
               n_fail++;
               $display("FAIL reset_cnt dut%0d ch%0d: got %0d want 0", d, ch, dut_cnt(d, ch));
            end
         end
      end
      reset = 1'b0;
   endtask

   task automatic test_counting();
      int unsigned cnts [NCH] = '{5, 0, 3, 12};
      logic [NCH-1:0] m;
      do_reset();
      for (int k = 0; k < 12; k++) begin
         for (int ch = 0; ch < NCH; ch++) m[ch] = (k < int'(cnts[ch]));
         pulses(m, 1);
      end
      slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[0] !== 1'b1) begin
         n_fail++; $display("FAIL count_valid: got %b want 1", v_o[0]);
      end
      for (int ch = 0; ch < NCH; ch++) begin
         n_run++;
         if (dut_cnt(0, ch) !== 32'(cnts[ch])) begin
            n_fail++; $display("FAIL count_ch%0d: got %0d want %0d", ch, dut_cnt(0, ch), cnts[ch]);
         end
      end
      n_run++;
      if ({sil_o[0], ovf_o[0], idx_o[0]} !== {4'b0010, 4'b0000, 16'd1}) begin
         n_fail++;
         $display("FAIL count_flags: got sil=%b ovf=%b idx=%0d want sil=0010 ovf=0000 idx=1",
                  sil_o[0], ovf_o[0], idx_o[0]);
      end
      slow_clk = 1'b0; tick();
      n_run++;
      if (v_o[0] !== 1'b0) begin
         n_fail++; $display("FAIL count_valid_pulse: got %b want 0", v_o[0]);
      end
   endtask

   task automatic test_coincident();
      do_reset();
      pulses(4'b0001, 2);
      spike = 4'b0001; slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[0] !== 1'b1 || dut_cnt(0, 0) !== 32'd2) begin
         n_fail++; $display("FAIL coincident_first: got v=%b cnt=%0d want v=1 cnt=2", v_o[0], dut_cnt(0, 0));
      end
      spike = '0; slow_clk = 1'b0; tick(); tick();
      slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[0] !== 1'b1 || dut_cnt(0, 0) !== 32'd1) begin
         n_fail++; $display("FAIL coincident_next: got v=%b cnt=%0d want v=1 cnt=1", v_o[0], dut_cnt(0, 0));
      end
      slow_clk = 1'b0; tick();
   endtask

   task automatic test_saturation();
      do_reset();
      pulses(4'b0010, 20);
      slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[1] !== 1'b1 || dut_cnt(1, 1) !== 32'd15 || ovf_o[1] !== 4'b0010) begin
         n_fail++;
         $display("FAIL sat_window: got v=%b cnt=%0d ovf=%b want v=1 cnt=15 ovf=0010",
                  v_o[1], dut_cnt(1, 1), ovf_o[1]);
      end
      n_run++;
      if (dut_cnt(0, 1) !== 32'd20 || ovf_o[0] !== 4'b0000) begin
         n_fail++; $display("FAIL sat_wide: got cnt=%0d ovf=%b want cnt=20 ovf=0000", dut_cnt(0, 1), ovf_o[0]);
      end
      slow_clk = 1'b0;
      pulses(4'b0010, 3);
      slow_clk = 1'b1; tick();
      n_run++;
      if (dut_cnt(1, 1) !== 32'd3 || ovf_o[1] !== 4'b0000) begin
         n_fail++; $display("FAIL sat_recover: got cnt=%0d ovf=%b want cnt=3 ovf=0000", dut_cnt(1, 1), ovf_o[1]);
      end
      slow_clk = 1'b0; tick();
   endtask

   task automatic test_reset_enable();
      do_reset();
      pulses(4'hF, 6);
      spike = 4'hF; tick(); tick();
      reset = 1'b1; tick(); tick();
      reset = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      slow_clk = 1'b1; tick();
      for (int ch = 0; ch < NCH; ch++) begin
         n_run++;
         if (dut_cnt(0, ch) !== 32'd0) begin
            n_fail++; $display("FAIL held_after_reset ch%0d: got %0d want 0", ch, dut_cnt(0, ch));
         end
      end
      n_run++;
      if ({v_o[0], sil_o[0], idx_o[0]} !== {1'b1, 4'hF, 16'd1}) begin
         n_fail++;
         $display("FAIL held_after_reset_flags: got v=%b sil=%b idx=%0d want v=1 sil=1111 idx=1",
                  v_o[0], sil_o[0], idx_o[0]);
      end
      slow_clk = 1'b0; enable = 1'b0;
      for (int k = 0; k < 12; k++) begin
         spike = 4'($urandom); tick();
      end
      slow_clk = 1'b1; tick();
      n_run++;
      if ({v_o[0], sil_o[0], idx_o[0], dut_cnt(0, 0), dut_cnt(0, 3)} !==
          {1'b1, 4'hF, 16'd2, 32'd0, 32'd0}) begin
         n_fail++;
         $display("FAIL disabled_window: got v=%b sil=%b idx=%0d c0=%0d c3=%0d want v=1 sil=1111 idx=2 c0=0 c3=0",
                  v_o[0], sil_o[0], idx_o[0], dut_cnt(0, 0), dut_cnt(0, 3));
      end
      enable = 1'b1; slow_clk = 1'b0; spike = '0; tick();
   endtask

   task automatic test_random_ext();
      do_reset();
      for (int k = 0; k < 400; k++) begin
         spike  = 4'($urandom);
         enable = ($urandom_range(3) != 0);
         if ($urandom_range(5) == 0) slow_clk = ~slow_clk;
         tick();
         for (int d = 0; d < ND; d++) begin
            n_run++;
            if (v_o[d] !== e_valid[d]) begin
               n_fail++; $display("FAIL rand_valid dut%0d cyc%0d: got %b want %b", d, cyc, v_o[d], e_valid[d]);
            end
            if (e_valid[d]) begin
               for (int ch = 0; ch < NCH; ch++) begin
                  n_run++;
                  if (dut_cnt(d, ch) !== e_cnt[d][ch]) begin
                     n_fail++;
                     $display("FAIL rand_cnt dut%0d ch%0d cyc%0d: got %0d want %0d",
                              d, ch, cyc, dut_cnt(d, ch), e_cnt[d][ch]);
                  end
               end
               n_run++;
               if ({ovf_o[d], sil_o[d], idx_o[d]} !== {e_ovf[d], e_sil[d], e_idx[d]}) begin
                  n_fail++;
                  $display("FAIL rand_flags dut%0d cyc%0d: got ovf=%b sil=%b idx=%0d want ovf=%b sil=%b idx=%0d",
                           d, cyc, ovf_o[d], sil_o[d], idx_o[d], e_ovf[d], e_sil[d], e_idx[d]);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         spike    = 4'($urandom);
         slow_clk = ~slow_clk;
         tick();
         for (int d = 0; d < ND; d++) begin
            n_run++;
            if (v_o[d] !== e_valid[d]) begin
               n_fail++; $display("FAIL b2b_valid dut%0d cyc%0d: got %b want %b", d, cyc, v_o[d], e_valid[d]);
            end
            if (e_valid[d]) begin
               for (int ch = 0; ch < NCH; ch++) begin
                  n_run++;
                  if (dut_cnt(d, ch) !== e_cnt[d][ch]) begin
                     n_fail++;
                     $display("FAIL b2b_cnt dut%0d ch%0d cyc%0d: got %0d want %0d",
                              d, ch, cyc, dut_cnt(d, ch), e_cnt[d][ch]);
                  end
               end
               n_run++;
               if ({ovf_o[d], sil_o[d], idx_o[d]} !== {e_ovf[d], e_sil[d], e_idx[d]}) begin
                  n_fail++;
                  $display("FAIL b2b_flags dut%0d cyc%0d: got ovf=%b sil=%b idx=%0d want ovf=%b sil=%b idx=%0d",
                           d, cyc, ovf_o[d], sil_o[d], idx_o[d], e_ovf[d], e_sil[d], e_idx[d]);
               end
            end
         end
      end
      slow_clk = 1'b0; spike = '0; tick();
   endtask

   task automatic test_internal();
      do_reset();
      for (int n = 1; n <= 35; n++) begin
         slow_clk = ~slow_clk;
         spike    = 4'($urandom);
         tick();
         n_run++;
         if (v_o[2] !== ((n % 10) == 0)) begin
            n_fail++; $display("FAIL int_valid cycle%0d: got %b want %b", n, v_o[2], ((n % 10) == 0));
         end
         if (e_valid[2]) begin
            for (int ch = 0; ch < NCH; ch++) begin
               n_run++;
               if (dut_cnt(2, ch) !== e_cnt[2][ch]) begin
                  n_fail++;
                  $display("FAIL int_cnt ch%0d cycle%0d: got %0d want %0d", ch, n, dut_cnt(2, ch), e_cnt[2][ch]);
               end
            end
            n_run++;
            if ({ovf_o[2], sil_o[2], idx_o[2]} !== {e_ovf[2], e_sil[2], e_idx[2]}) begin
               n_fail++;
               $display("FAIL int_flags cycle%0d: got ovf=%b sil=%b idx=%0d want ovf=%b sil=%b idx=%0d",
                        n, ovf_o[2], sil_o[2], idx_o[2], e_ovf[2], e_sil[2], e_idx[2]);
            end
         end
      end
      slow_clk = 1'b0; spike = '0; tick();
   endtask

   // 65536 real windows would take too long; preload the index just below the wrap point.
   task automatic test_wrap();
      do_reset();
      force dut_a.r_win_idx = 16'hFFFE;
      force_req = 1'b1;
      tick();
      force_req = 1'b0;
      release dut_a.r_win_idx;
      tick();
      n_run++;
      if (idx_o[0] !== 16'hFFFE) begin
         n_fail++; $display("FAIL wrap_preload: got %0d want 65534", idx_o[0]);
      end
      slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[0] !== 1'b1 || idx_o[0] !== 16'hFFFF) begin
         n_fail++; $display("FAIL wrap_last: got v=%b idx=%0d want v=1 idx=65535", v_o[0], idx_o[0]);
      end
      slow_clk = 1'b0; tick();
      slow_clk = 1'b1; tick();
      n_run++;
      if (v_o[0] !== 1'b1 || idx_o[0] !== 16'd0 || idx_o[0] !== e_idx[0]) begin
         n_fail++;
         $display("FAIL wrap_zero: got v=%b idx=%0d want v=1 idx=0 (model %0d)", v_o[0], idx_o[0], e_idx[0]);
      end
      slow_clk = 1'b0; tick();
   endtask

   initial begin
      n_run = 0; n_fail = 0; cyc = 0; force_req = 1'b0;
      reset = 1'b1; spike = '0; slow_clk = 1'b0; enable = 1'b1;
      test_reset();
      test_counting();
      test_coincident();
      test_saturation();
      test_reset_enable();
      test_random_ext();
      test_back_to_back();
      test_internal();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
